// File: rtl/div_arbiter.sv
// Two-requester front end for a shared iterative divider.
// Round-robin acceptance, operand latching, annul handling and a fixed drain.
module div_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        signed0_i,
    input  logic        signed1_i,
    input  logic [31:0] op1_0_i,
    input  logic [31:0] op2_0_i,
    input  logic [31:0] op1_1_i,
    input  logic [31:0] op2_1_i,
    input  logic        annul0_i,
    input  logic        annul1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [63:0] result_o,
    output logic        div_zero_o,
    output logic        busy_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_drain;
    logic        w_drain_nxt;

    logic        r_rr;
    logic        r_owner;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic        r_annul;
    logic [63:0] r_result;
    logic        r_zero;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_idle;
    logic        w_run;
    logic        w_accept;
    logic        w_pick;
    logic        w_own_annul;
    logic        w_run_annul;
    logic        w_run_done;
    logic        w_op2_zero;

    assign w_elig0     = req0_i & ~annul0_i;
    assign w_elig1     = req1_i & ~annul1_i;
    assign w_idle      = (r_state == IDLE);
    assign w_run       = (r_state == RUN);
    assign w_accept    = w_idle & (w_elig0 | w_elig1);
    assign w_own_annul = r_owner ? annul1_i : annul0_i;
    // Annul beats a coincident ready: the result is discarded.
    assign w_run_annul = w_run & w_own_annul;
    assign w_run_done  = w_run & ~w_own_annul & div_ready_i;
    assign w_op2_zero  = (r_op2 == 32'h0);

    // r_rr names the requester preferred on a tie.
    always_comb begin
        w_pick = 1'b0;
        unique case (1'b1)
            (w_elig0 & w_elig1):  w_pick = r_rr;
            (w_elig0 & ~w_elig1): w_pick = 1'b0;
            (~w_elig0 & w_elig1): w_pick = 1'b1;
            default:              w_pick = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_run_annul || w_run_done) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = IDLE;
                end
                w_drain_nxt = ~r_drain;
            end
            default: begin
                w_state_nxt = IDLE;
                w_drain_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Operands change only on acceptance, so they stay put until IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_op1    <= 32'h0;
            r_op2    <= 32'h0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_rr     <= ~w_pick;
            r_owner  <= w_pick;
            r_op1    <= w_pick ? op1_1_i : op1_0_i;
            r_op2    <= w_pick ? op2_1_i : op2_0_i;
            r_signed <= w_pick ? signed1_i : signed0_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_annul <= 1'b0;
        end else begin
            r_gnt0  <= w_accept & ~w_pick;
            r_gnt1  <= w_accept & w_pick;
            r_done0 <= w_run_done & ~r_owner;
            r_done1 <= w_run_done & r_owner;
            r_annul <= w_run_annul;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= 64'h0;
            r_zero   <= 1'b0;
        end else if (w_run_done) begin
            r_result <= w_op2_zero ? 64'h0 : div_result_i;
            r_zero   <= w_op2_zero;
        end
    end

    assign gnt0_o       = r_gnt0;
    assign gnt1_o       = r_gnt1;
    assign done0_o      = r_done0;
    assign done1_o      = r_done1;
    assign result_o     = r_result;
    assign div_zero_o   = r_zero;
    assign busy_o       = ~w_idle;
    assign div_start_o  = w_run;
    assign div_annul_o  = r_annul;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider and
// an arithmetic reference for quotient/remainder and grant order.
module tb_div_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_i, req1_i;
    logic        signed0_i, signed1_i;
    logic [31:0] op1_0_i, op2_0_i, op1_1_i, op2_1_i;
    logic        annul0_i, annul1_i;
    logic        gnt0_o, gnt1_o, done0_o, done1_o;
    logic [63:0] result_o;
    logic        div_zero_o, busy_o, div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    div_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_i(req0_i), .req1_i(req1_i),
        .signed0_i(signed0_i), .signed1_i(signed1_i),
        .op1_0_i(op1_0_i), .op2_0_i(op2_0_i),
        .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
        .annul0_i(annul0_i), .annul1_i(annul1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .done0_o(done0_o), .done1_o(done1_o),
        .result_o(result_o), .div_zero_o(div_zero_o),
        .busy_o(busy_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i)
    );

    typedef struct {
        logic        ann;
        int          who;
        logic [63:0] res;
        logic        z;
    } exp_t;

    exp_t exp_done[$];
    int   exp_gnt[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rr_m = 0;
    int   lat_cfg = 4;
    int   cnt = 0;
    int   cyc = 0;
    int   evt = -10;
    logic [63:0] last_res = 64'h0;
    logic        last_z = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endfunction

    // Quotient/remainder as the arbiter must report them (zero on /0).
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider side: RISC-V style junk on /0, which the arbiter must mask.
    function automatic logic [63:0] unit_div(input logic s, input logic [31:0] a,
                                             input logic [31:0] b);
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return ref_div(s, a, b);
    endfunction

    always @(negedge clk) begin
        if (!rst || !div_start_o) begin
            cnt = 0;
            div_ready_i = ($urandom_range(0, 3) == 0);
            div_result_i = {$urandom, $urandom};
        end else begin
            cnt++;
            div_ready_i = (cnt == lat_cfg);
            div_result_i = div_ready_i ?
                unit_div(div_signed_o, div_op1_o, div_op2_o) : {$urandom, $urandom};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int o;
        cyc++;
        if (!rst) begin
            last_res = 64'h0;
            last_z = 1'b0;
            evt = -10;
        end else begin
            if (gnt0_o || gnt1_o) begin
                if (exp_gnt.size() == 0) flag("gnt_unexpected");
                else begin
                    o = exp_gnt.pop_front();
                    chk("gnt_owner", {62'h0, gnt1_o, gnt0_o}, (o == 1) ? 64'd2 : 64'd1);
                    chk("gnt_run", {62'h0, busy_o, div_start_o}, 64'd3);
                end
            end
            if (done0_o || done1_o || div_annul_o) begin
                evt = cyc;
                chk("drain_start", {63'h0, div_start_o}, 64'd0);
                if (exp_done.size() == 0) flag("done_unexpected");
                else begin
                    e = exp_done.pop_front();
                    chk("done_kind", {61'h0, div_annul_o, done1_o, done0_o},
                        e.ann ? 64'd4 : ((e.who == 1) ? 64'd2 : 64'd1));
                    chk("result", result_o, e.ann ? last_res : e.res);
                    chk("div_zero", {63'h0, div_zero_o}, {63'h0, e.ann ? last_z : e.z});
                    if (!e.ann) begin
                        last_res = e.res;
                        last_z = e.z;
                    end
                end
            end
            if (cyc == evt + 1) chk("drain2", {62'h0, busy_o, div_start_o}, 64'd2);
            if (cyc == evt + 2) chk("drain_end", {63'h0, busy_o}, 64'd0);
        end
    end

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 32'h80000000;
            1: return $urandom_range(0, 200);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_div();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_rst_outs(input string nm);
        chk({nm, "_ctrl"}, {55'h0, gnt0_o, gnt1_o, done0_o, done1_o, div_zero_o,
            busy_o, div_start_o, div_annul_o, div_signed_o}, 64'h0);
        chk({nm, "_result"}, result_o, 64'h0);
        chk({nm, "_ops"}, {div_op1_o, div_op2_o}, 64'h0);
    endtask

    task automatic do_op(input int who, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int ann_at);
        exp_t e;
        int n;
        int c;
        lat_cfg = lat;
        @(negedge clk);
        req0_i = (who == 0);
        req1_i = (who == 1);
        if (who == 0) begin
            signed0_i = sgn; op1_0_i = a; op2_0_i = b;
        end else begin
            signed1_i = sgn; op1_1_i = a; op2_1_i = b;
        end
        exp_gnt.push_back(who);
        e.ann = (ann_at > 0 && ann_at <= lat);
        e.who = who;
        e.res = ref_div(sgn, a, b);
        e.z = (b == 32'h0);
        exp_done.push_back(e);
        rr_m = (who == 0) ? 1 : 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0_o || gnt1_o) && n < 50);
        chk("gnt_latency", n, 1);
        req0_i = 1'b0;
        req1_i = 1'b0;
        c = 1;
        while (c < 300) begin
            op1_0_i = $urandom; op2_0_i = $urandom; signed0_i = $urandom_range(0, 1);
            op1_1_i = $urandom; op2_1_i = $urandom; signed1_i = $urandom_range(0, 1);
            if (who == 0) begin
                annul0_i = (c == ann_at);
                annul1_i = ($urandom_range(0, 1) == 1);
            end else begin
                annul1_i = (c == ann_at);
                annul0_i = ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            c++;
            if (!busy_o) break;
        end
        annul0_i = 1'b0;
        annul1_i = 1'b0;
        if (busy_o) flag("op_timeout");
    endtask

    task automatic do_tie(input int lat);
        exp_t e;
        int first, t, t0, t1;
        bit g0, g1;
        logic [31:0] a0, b0, a1, b1;
        logic s0, s1;
        a0 = rand_op(); b0 = rand_div(); s0 = $urandom_range(0, 1);
        a1 = rand_op(); b1 = rand_div(); s1 = $urandom_range(0, 1);
        lat_cfg = lat;
        @(negedge clk);
        req0_i = 1'b1; signed0_i = s0; op1_0_i = a0; op2_0_i = b0;
        req1_i = 1'b1; signed1_i = s1; op1_1_i = a1; op2_1_i = b1;
        annul0_i = 1'b0;
        annul1_i = 1'b0;
        first = rr_m;
        exp_gnt.push_back(first);
        exp_gnt.push_back(1 - first);
        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? first : 1 - first;
            e.ann = 1'b0;
            e.who = w;
            e.res = (w == 0) ? ref_div(s0, a0, b0) : ref_div(s1, a1, b1);
            e.z = (w == 0) ? (b0 == 32'h0) : (b1 == 32'h0);
            exp_done.push_back(e);
        end
        t = 0; t0 = 0; t1 = 0; g0 = 0; g1 = 0;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (gnt0_o) begin g0 = 1; t0 = t; req0_i = 1'b0; end
            if (gnt1_o) begin g1 = 1; t1 = t; req1_i = 1'b0; end
            if (g0 && g1 && !busy_o) break;
        end
        req0_i = 1'b0;
        req1_i = 1'b0;
        if (!(g0 && g1) || busy_o) flag("tie_timeout");
        else chk("tie_spacing", (first == 1) ? t0 - t1 : t1 - t0, lat + 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_i = 0; req1_i = 0; signed0_i = 0; signed1_i = 0;
        op1_0_i = 0; op2_0_i = 0; op1_1_i = 0; op2_1_i = 0;
        annul0_i = 0; annul1_i = 0;
        div_ready_i = 0; div_result_i = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        req0_i = 1'b1;
        op1_0_i = 32'h1234;
        op2_0_i = 32'h5;
        @(negedge clk);
        chk_rst_outs("reset");
        req0_i = 1'b0;
        rst = 1'b1;

        do_op(0, 1'b0, 32'd100, 32'd7, 5, -1);
        do_op(1, 1'b1, -32'sd100, 32'd7, 6, -1);

        do_tie(4);
        do_op(0, 1'b0, 32'd55, 32'd6, 2, -1);
        do_tie(3);

        do_op(0, 1'b0, 32'd1234, 32'd0, 4, -1);
        do_op(0, 1'b0, 32'd50, 32'd5, 3, -1);

        do_op(0, 1'b0, 32'd1000, 32'd3, 20, 10);
        do_op(0, 1'b0, 32'd9, 32'd3, 3, -1);
        do_op(1, 1'b0, 32'd77, 32'd5, 7, 7);
        do_op(1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1, -1);

        @(negedge clk);
        req0_i = 1'b1;
        annul0_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("annul_blocks_req", {63'h0, busy_o}, 64'd0);
        req0_i = 1'b0;
        annul0_i = 1'b0;

        for (int k = 0; k < 60; k++) begin
            int lat, ann;
            if ($urandom_range(0, 9) < 2) do_tie($urandom_range(1, 8));
            else begin
                lat = $urandom_range(1, 12);
                ann = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 2) : -1;
                do_op($urandom_range(0, 1), $urandom_range(0, 1), rand_op(),
                      rand_div(), lat, ann);
            end
        end

        lat_cfg = 40;
        @(negedge clk);
        req0_i = 1'b1; signed0_i = 1'b0; op1_0_i = 32'd500; op2_0_i = 32'd9;
        exp_gnt.push_back(0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt0_o && n < 50);
            chk("rst_run_gnt", n, 1);
        end
        req0_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        exp_done.delete();
        exp_gnt.delete();
        rr_m = 0;
        #1 chk_rst_outs("async_rst");
        repeat (2) @(negedge clk);
        chk_rst_outs("held_rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {63'h0, busy_o}, 64'd0);
        do_op(1, 1'b1, -32'sd100, 32'd7, 5, -1);
        do_tie(2);

        repeat (4) @(negedge clk);
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on rst low, independent of clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_i / req1_i  in  1  requester n asks for a divide (level).
- signed0_i / signed1_i  in  1  1 = signed divide, 0 = unsigned.
- op1_0_i, op2_0_i / op1_1_i, op2_1_i  in  32  requester n dividend / divisor.
- annul0_i / annul1_i  in  1  requester n cancels its request or its in-flight operation.
- gnt0_o / gnt1_o  out  1  one-cycle pulse: requester n's operands have been captured.
- done0_o / done1_o  out  1  one-cycle pulse: result_o is valid for requester n.
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- div_zero_o  out  1  qualifies done: the captured divisor was 0.
- busy_o  out  1  the divider is owned or draining.
- div_start_o  out  1  start to the divider.
- div_annul_o  out  1  annul to the divider.
- div_signed_o  out  1  signed select to the divider.
- div_op1_o, div_op2_o  out  32  operands to the divider.
- div_result_i  in  64  result from the divider.
- div_ready_i  in  1  ready from the divider.

Function
REQ-003 The state machine SHALL have three states: IDLE, RUN, DRAIN.
REQ-004 IDLE acceptance: a requester is eligible when req_i=1 and annul_i=0.
- One eligible requester: that requester SHALL be accepted.
- Both eligible: the requester not granted last SHALL be accepted (round-robin).
REQ-005 On acceptance the block SHALL:
- latch that requester's op1, op2 and signed into internal registers;
- record the owner;
- update the round-robin pointer;
- pulse the owner's gnt_o in the next cycle;
- enter RUN.
REQ-006 div_op1_o, div_op2_o and div_signed_o SHALL be driven only from the latched registers and SHALL stay stable from RUN entry until IDLE is re-entered, because the divider re-samples operand sign bits at completion.
REQ-007 div_start_o SHALL be 1 in RUN and 0 in IDLE and DRAIN.
REQ-008 Normal completion: in RUN, on an edge where div_ready_i=1, the block SHALL:
- register div_result_i into result_o;
- register (latched op2 == 0) into div_zero_o;
- pulse the owner's done_o for exactly the next cycle;
- enter DRAIN.
REQ-009 Divide by zero SHALL complete through the same path with result_o = 0 and div_zero_o = 1.
REQ-010 Annul in RUN: if the owner's annul_i=1 and div_ready_i=0, the block SHALL:
- assert div_annul_o for exactly the next cycle;
- enter DRAIN with no done pulse.
REQ-011 If annul_i and div_ready_i are both 1 in the same RUN cycle, annul SHALL win: no done pulse, result_o unchanged.
REQ-012 DRAIN SHALL last exactly 2 cycles with div_start_o=0 and then return to IDLE, guaranteeing the divider is back in its free state from any state, including its divide-by-zero path.
REQ-013 div_ready_i SHALL be ignored outside RUN.
REQ-014 Requests arriving in RUN or DRAIN SHALL not be accepted; they SHALL wait, and they SHALL be accepted in IDLE only if still asserted.
REQ-015 annul_i from the non-owner SHALL be ignored.
REQ-016 busy_o SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-017 result_o and div_zero_o SHALL hold their values until the next completion.
REQ-018 Minimum spacing between two acceptances SHALL be the divider latency + 3 cycles (RUN exit + 2 DRAIN).

Reset
REQ-019 While rst=0, the block SHALL:
- be in state IDLE;
- point round-robin at requester 0;
- drive all outputs to 0, including result_o=64'h0 and all latched operands=0.
REQ-020 Reset mid-operation SHALL abandon the owner silently, with no done and no annul pulse; the divider is reset by the same signal.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- req0, unsigned, 100/7 -> gnt0 one cycle later; result_o = {32'd2, 32'd14}; single done0 pulse; DRAIN of 2 cycles; busy_o drops.
- req1, signed, -100/7 -> result_o = {32'hFFFFFFFE, 32'hFFFFFFF2}; done1 only.
- req0 and req1 together from reset -> req0 granted first; req1 held high is granted after the first completion's DRAIN; pointer alternates on a repeated tie.
- req0 with op2 = 0 -> done0 with result_o = 0 and div_zero_o = 1; the next request completes normally.
- annul0 10 cycles into RUN -> div_annul_o pulses once; no done0; busy_o low after 2 DRAIN cycles; a following 9/3 returns {0, 3}.
- rst low mid-RUN, then released -> all outputs 0 and state IDLE; a new request completes correctly.
